regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter sharing the register file's single write port (we/rd/rd_data) between two producers: A (ALU/execute result) and B (load unit). Each producer hands off through a valid/ready handshake into a one-entry holding register. The arbiter picks one held entry per cycle and drives a registered write to the register file. It also exports a pending-destination mask for hazard detection.

## Interface
Parameters:
- XLEN, 32, data width.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  A offers a write.
- a_ready  out  1  A holding register can accept.
- a_rd  in  5  A destination register.
- a_data  in  XLEN  A write data.
- b_valid, b_ready, b_rd, b_data: same as the A ports, for requester B.
- we  out  1  register file write enable (registered).
- rd  out  5  register file write address (registered).
- rd_data  out  XLEN  register file write data (registered).
- pending  out  32  bit i set when a write to xi is held or on the write port; bit 0 always 0.
- conflict_cnt  out  CNT_W  cycles in which both holding registers were valid.

## Operation
- Holding registers hold_a and hold_b each store {valid, rd, data}.
- Accept: a handshake (x_valid & x_ready) at an edge loads hold_x, unless x_rd == 0. A write to x0 completes the handshake but is discarded, and hold_x is not loaded.
- Ready: x_ready = !hold_x.valid | grant_x. A granted entry can be replaced in the same cycle, giving one write per cycle per requester with no bubble.
- Arbitration is combinational on the hold valids:
  - Only one valid: it is granted.
  - Both valid: the policy is set by Configuration.
  - Neither valid: no grant.
- Output stage at each edge:
  - we <= any grant.
  - rd and rd_data <= the granted entry's fields.
  - The granted hold is cleared, unless it is reloaded by a simultaneous handshake.
  - With no grant, rd and rd_data hold their previous values.
- Both requesters targeting the same rd: the writes commit in grant order, and the later grant's data is final. No merging is performed.
- pending = decode(hold_a) | decode(hold_b) | (we ? decode(rd) : 0), with bit 0 forced to 0.
- conflict_cnt increments on every cycle in which both holds are valid, and saturates at all-ones.
- Reset values:
  - Outputs: we=0, rd=0, rd_data=0, pending=0, conflict_cnt=0.
  - Internal: both holds invalid; last_grant=B.
  - a_ready=1 and b_ready=1 in the first cycle after reset.
- Reset mid-operation: held and in-flight writes are dropped. A we that is registered high is deasserted at the reset edge, so the register file never sees a partial write.

## Timing
- Handshake at edge N loads the hold.
- At edge N+1 the hold is granted (if uncontested) and we/rd/rd_data are registered high.
- The register file commits at edge N+2. Minimum handshake-to-commit latency is 2 edges.
- A losing entry waits one cycle per lost arbitration. While it waits, its x_ready stays 0.
- pending reflects the holds and the output stage in the same cycle they are registered. A destination is covered continuously from the edge after acceptance until the register file commit edge.
- Throughput:
  - One register file write per cycle total.
  - Sustained A+B traffic of 2 per cycle backpressures the requesters to 1 per cycle total.

## Configuration
- WB_RR_EN defined: round-robin arbitration.
  - On a conflict, grant the requester not in last_grant.
  - last_grant updates on every grant.
  - No requester waits more than one cycle.
- WB_RR_EN undefined: fixed priority, A over B.
  - last_grant is unused.
  - B may starve under continuous A traffic.

## Test plan
- After reset, A writes x5=0x1234 → we=1, rd=5, rd_data=0x1234 one edge after the handshake. pending[5]=1 from the edge after acceptance until the commit edge.
- A and B handshake in the same cycle, A x3=0xAA and B x3=0xBB:
  - With WB_RR_EN: A is written first, then B, and final x3=0xBB. b_ready=0 for one cycle. conflict_cnt=1.
  - Without WB_RR_EN: same result.
- Continuous valid on both requesters for 6 cycles:
  - With WB_RR_EN: grants alternate A,B,A,B,A,B.
  - Without WB_RR_EN: six A grants, and b_ready=0 throughout.
- A writes to rd=0 with data 0xFFFF → handshake completes, we stays 0, pending stays 0.
- rst asserted while hold_b is valid and we=1 → at the next edge we=0, pending=0, conflict_cnt=0, and both readys are 1.
- Force 2^CNT_W+3 conflict cycles → conflict_cnt holds at all-ones.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two producers (A = execute, B = load) share the single
// register-file write port through one-entry holding registers.
// Optional feature macro: WB_RR_EN (round-robin on conflict); default is fixed
// priority with A over B.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [4:0]       a_rd,
  input  logic [XLEN-1:0]  a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_rd,
  input  logic [XLEN-1:0]  b_data,
  output logic             we,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  rd_data,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Holding registers
  logic            hold_a_valid_q, hold_a_valid_d;
  logic [4:0]      hold_a_rd_q, hold_a_rd_d;
  logic [XLEN-1:0] hold_a_data_q, hold_a_data_d;
  logic            hold_b_valid_q, hold_b_valid_d;
  logic [4:0]      hold_b_rd_q, hold_b_rd_d;
  logic [XLEN-1:0] hold_b_data_q, hold_b_data_d;

  // Output stage
  logic            we_q, we_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic grant_a, grant_b;
  logic both_valid;
  logic load_a, load_b;

  function automatic logic [31:0] dec_rd(input logic [4:0] r);
    dec_rd = 32'd1 << r;
  endfunction

  assign both_valid = hold_a_valid_q & hold_b_valid_q;

`ifdef WB_RR_EN
  // 1 means B was granted most recently.
  logic last_grant_q, last_grant_d;

  // Round-robin: on conflict, grant whoever was not granted last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (both_valid) begin
      grant_a = last_grant_q;
      grant_b = ~last_grant_q;
    end else begin
      grant_a = hold_a_valid_q;
      grant_b = hold_b_valid_q;
    end
  end

  // Track the most recent grant.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_a) begin
      last_grant_d = 1'b0;
    end else if (grant_b) begin
      last_grant_d = 1'b1;
    end
  end

  // last_grant register, resets to B so A wins the first conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed priority: A always wins a conflict.
  always_comb begin
    grant_a = hold_a_valid_q;
    grant_b = hold_b_valid_q & ~hold_a_valid_q;
  end
`endif

  assign a_ready = ~hold_a_valid_q | grant_a;
  assign b_ready = ~hold_b_valid_q | grant_b;

  // Writes to x0 complete the handshake but are dropped here.
  assign load_a = a_valid & a_ready & (a_rd != 5'd0);
  assign load_b = b_valid & b_ready & (b_rd != 5'd0);

  // Holding register next state: reload wins over clear-on-grant.
  always_comb begin
    hold_a_valid_d = hold_a_valid_q;
    hold_a_rd_d    = hold_a_rd_q;
    hold_a_data_d  = hold_a_data_q;
    hold_b_valid_d = hold_b_valid_q;
    hold_b_rd_d    = hold_b_rd_q;
    hold_b_data_d  = hold_b_data_q;
    if (load_a) begin
      hold_a_valid_d = 1'b1;
      hold_a_rd_d    = a_rd;
      hold_a_data_d  = a_data;
    end else if (grant_a) begin
      hold_a_valid_d = 1'b0;
    end
    if (load_b) begin
      hold_b_valid_d = 1'b1;
      hold_b_rd_d    = b_rd;
      hold_b_data_d  = b_data;
    end else if (grant_b) begin
      hold_b_valid_d = 1'b0;
    end
  end

  // Output stage next state: address/data hold when nothing is granted.
  always_comb begin
    we_d      = grant_a | grant_b;
    rd_d      = rd_q;
    rd_data_d = rd_data_q;
    if (grant_a) begin
      rd_d      = hold_a_rd_q;
      rd_data_d = hold_a_data_q;
    end else if (grant_b) begin
      rd_d      = hold_b_rd_q;
      rd_data_d = hold_b_data_q;
    end
  end

  // Saturating conflict counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (both_valid && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset drops held and in-flight writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_a_valid_q <= 1'b0;
      hold_a_rd_q    <= 5'd0;
      hold_a_data_q  <= '0;
      hold_b_valid_q <= 1'b0;
      hold_b_rd_q    <= 5'd0;
      hold_b_data_q  <= '0;
      we_q           <= 1'b0;
      rd_q           <= 5'd0;
      rd_data_q      <= '0;
      cnt_q          <= '0;
    end else begin
      hold_a_valid_q <= hold_a_valid_d;
      hold_a_rd_q    <= hold_a_rd_d;
      hold_a_data_q  <= hold_a_data_d;
      hold_b_valid_q <= hold_b_valid_d;
      hold_b_rd_q    <= hold_b_rd_d;
      hold_b_data_q  <= hold_b_data_d;
      we_q           <= we_d;
      rd_q           <= rd_d;
      rd_data_q      <= rd_data_d;
      cnt_q          <= cnt_d;
    end
  end

  // Pending destinations: held entries plus the write on the port; x0 never pending.
  always_comb begin
    pending = 32'd0;
    if (hold_a_valid_q) pending = pending | dec_rd(hold_a_rd_q);
    if (hold_b_valid_q) pending = pending | dec_rd(hold_b_rd_q);
    if (we_q)           pending = pending | dec_rd(rd_q);
    pending[0] = 1'b0;
  end

  assign we           = we_q;
  assign rd           = rd_q;
  assign rd_data      = rd_data_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expectations follow WB_RR_EN if defined.
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             a_valid, b_valid;
  logic             a_ready, b_ready;
  logic [4:0]       a_rd, b_rd;
  logic [XLEN-1:0]  a_data, b_data;
  logic             we;
  logic [4:0]       rd;
  logic [XLEN-1:0]  rd_data;
  logic [31:0]      pending;
  logic [CNT_W-1:0] conflict_cnt;

  int total;
  int bad;

  regfile_wb_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_rd         (a_rd),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_rd         (b_rd),
    .b_data       (b_data),
    .we           (we),
    .rd           (rd),
    .rd_data      (rd_data),
    .pending      (pending),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    a_valid = 1'b0; a_rd = 5'd0; a_data = '0;
    b_valid = 1'b0; b_rd = 5'd0; b_data = '0;

    // Reset state
    do_reset();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd1);
    chk("rst_b_ready", 64'(b_ready), 64'd1);

    // Single A write x5 = 0x1234
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234;
    cyc();
    a_valid = 1'b0;
    chk("t1_we_n", 64'(we), 64'd0);
    chk("t1_pend_n", 64'(pending), 64'h20);
    cyc();
    chk("t1_we", 64'(we), 64'd1);
    chk("t1_rd", 64'(rd), 64'd5);
    chk("t1_data", 64'(rd_data), 64'h1234);
    chk("t1_pend_n1", 64'(pending), 64'h20);
    cyc();
    chk("t1_we_n2", 64'(we), 64'd0);
    chk("t1_pend_n2", 64'(pending), 64'd0);
    chk("t1_rd_hold", 64'(rd), 64'd5);

    // Same-rd conflict: A x3=0xAA, B x3=0xBB
    do_reset();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hAA;
    b_valid = 1'b1; b_rd = 5'd3; b_data = 32'hBB;
    cyc();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t2_b_ready_wait", 64'(b_ready), 64'd0);
    chk("t2_a_ready", 64'(a_ready), 64'd1);
    chk("t2_pend", 64'(pending), 64'h8);
    cyc();
    chk("t2_we1", 64'(we), 64'd1);
    chk("t2_rd1", 64'(rd), 64'd3);
    chk("t2_data1", 64'(rd_data), 64'hAA);
    chk("t2_cnt", 64'(conflict_cnt), 64'd1);
    chk("t2_b_ready", 64'(b_ready), 64'd1);
    cyc();
    chk("t2_we2", 64'(we), 64'd1);
    chk("t2_data2", 64'(rd_data), 64'hBB);
    cyc();
    chk("t2_we3", 64'(we), 64'd0);
    chk("t2_cnt_end", 64'(conflict_cnt), 64'd1);
    chk("t2_pend_end", 64'(pending), 64'd0);

    // Continuous traffic on both requesters for 6 grants
    do_reset();
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 32'hB;
    cyc();
    for (int k = 0; k < 6; k++) begin
      cyc();
`ifdef WB_RR_EN
      chk("t3_rd", 64'(rd), (k % 2 == 0) ? 64'd1 : 64'd2);
      chk("t3_data", 64'(rd_data), (k % 2 == 0) ? 64'hA : 64'hB);
`else
      chk("t3_rd", 64'(rd), 64'd1);
      chk("t3_data", 64'(rd_data), 64'hA);
      chk("t3_b_ready", 64'(b_ready), 64'd0);
`endif
      chk("t3_we", 64'(we), 64'd1);
    end
    chk("t3_cnt", 64'(conflict_cnt), 64'd6);
    chk("t3_pend", 64'(pending), 64'h6);

    // Reset mid-operation: holds valid and we high
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    cyc();
    rst = 1'b0;
    chk("t4_we", 64'(we), 64'd0);
    chk("t4_pend", 64'(pending), 64'd0);
    chk("t4_cnt", 64'(conflict_cnt), 64'd0);
    chk("t4_a_ready", 64'(a_ready), 64'd1);
    chk("t4_b_ready", 64'(b_ready), 64'd1);
    cyc();
    chk("t4_we_after", 64'(we), 64'd0);

    // Write to x0 is accepted and discarded
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF;
    chk("t5_a_ready", 64'(a_ready), 64'd1);
    cyc();
    a_valid = 1'b0;
    chk("t5_pend", 64'(pending), 64'd0);
    chk("t5_we", 64'(we), 64'd0);
    chk("t5_a_ready_after", 64'(a_ready), 64'd1);
    cyc();
    chk("t5_we2", 64'(we), 64'd0);
    chk("t5_pend2", 64'(pending), 64'd0);

    // Counter saturation over 2^CNT_W + 3 conflict cycles
    do_reset();
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h7;
    b_valid = 1'b1; b_rd = 5'd8; b_data = 32'h8;
    cyc();
    repeat (10) cyc();
    chk("t6_cnt10", 64'(conflict_cnt), 64'd10);
    repeat (65525) cyc();
    chk("t6_cnt_max", 64'(conflict_cnt), 64'hFFFF);
    repeat (4) cyc();
    chk("t6_cnt_sat", 64'(conflict_cnt), 64'hFFFF);
    a_valid = 1'b0; b_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
